// File: rtl/ahb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_pkg : shared AHB-Lite encodings, default-slave state, sizing     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ahb_pkg;

  localparam int NSLV_DEF = 8;
  localparam int DW_DEF   = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_default_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_default_slave : two-cycle ERROR responder for unmapped accesses  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic hready_i,
  input  logic req_i,
  output logic hreadyout_o,
  output logic hresp_o
);

  ds_state_e state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state kept apart from outputs so hready_i never feeds hreadyout_o.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: if (hready_i && req_i) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: if (hready_i) state_d = req_i ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  always_comb begin
    hreadyout_o = 1'b1;
    hresp_o     = HRESP_OKAY;
    case (state_q)
      DS_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = HRESP_ERROR;
      end
      DS_ERR2: hresp_o = HRESP_ERROR;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ahb_slave_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_slave_mux : AHB-Lite data-phase response mux with default slave  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ahb_slave_mux
  import ahb_pkg::*;
#(
  parameter int              NSLV      = NSLV_DEF,
  parameter int              DW        = DW_DEF,
  parameter logic [DW-1:0]   DEF_RDATA = '0
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NSLV-1:0]      HSEL,
  input  logic [1:0]           HTRANS,
  input  logic [NSLV*DW-1:0]   HRDATA_S,
  input  logic [NSLV-1:0]      HREADYOUT_S,
  input  logic [NSLV-1:0]      HRESP_S,
  output logic [DW-1:0]        HRDATA,
  output logic                 HREADY,
  output logic                 HRESP
);

  localparam logic [NSLV:0] SEL_DEFAULT = {1'b1, {NSLV{1'b0}}};

  logic [NSLV:0]  sel_q, sel_d, owner;
  logic [DW-1:0]  rdata_s [NSLV];
  logic           def_req, def_ready, def_resp;

  for (genvar g = 0; g < NSLV; g++) begin : g_unpack
    assign rdata_s[g] = HRDATA_S[g*DW +: DW];
  end

  assign def_req = (HSEL == '0) && htrans_active(HTRANS);

  // Descending scan so the lowest set HSEL bit is the last (winning) write.
  always_comb begin
    owner       = '0;
    owner[NSLV] = 1'b1;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (HSEL[i]) begin
        owner    = '0;
        owner[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_d = sel_q;
    if (HREADY) sel_d = owner;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sel_q <= SEL_DEFAULT;
    end else begin
      sel_q <= sel_d;
    end
  end

  ahb_default_slave u_def (
    .clk_i       (HCLK),
    .rst_i       (HRESET),
    .hready_i    (HREADY),
    .req_i       (def_req),
    .hreadyout_o (def_ready),
    .hresp_o     (def_resp)
  );

  // Defaults double as the fallback for an all-zero sel_q.
  always_comb begin
    HRDATA = DEF_RDATA;
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q[i]) begin
        HRDATA = rdata_s[i];
        HREADY = HREADYOUT_S[i];
        HRESP  = HRESP_S[i];
      end
    end
    if (sel_q[NSLV]) begin
      HREADY = def_ready;
      HRESP  = def_resp;
    end
  end

endmodule
`default_nettype wire
